// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler sharing one loadable up-counter among NUM_REQ requesters.
// Optional abort input/aborted flag when CNT_SCHED_ABORT_EN is defined.
module counter_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_start,
    input  logic [NUM_REQ*WIDTH-1:0] req_len,
    input  logic [WIDTH-1:0]         cnt_value,
    output logic                     cnt_ld,
    output logic [WIDTH-1:0]         cnt_ld_val,
    output logic                     cnt_inc,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic [NUM_REQ-1:0]       done,
    output logic [WIDTH-1:0]         result
`ifdef CNT_SCHED_ABORT_EN
    ,
    input  logic                     abort,
    output logic                     aborted
`endif
);
    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             r_state, w_state;
    logic [IDXW-1:0]    r_last, r_idx, w_last, w_idx, w_pick;
    logic [WIDTH-1:0]   r_rem, w_rem, w_ld_val, w_result, w_pstart, w_plen;
    logic [NUM_REQ-1:0] w_gnt, w_done;
    logic               w_found, w_busy, w_ld, w_inc, w_abort, w_end;
    int                 w_j;

`ifdef CNT_SCHED_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Search upward from the requester after the last one served.
    always_comb begin
        w_found  = 1'b0;
        w_pick   = '0;
        w_pstart = '0;
        w_plen   = '0;
        w_j      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_j = (int'(r_last) + k) % NUM_REQ;
            if (!w_found && req[w_j]) begin
                w_found  = 1'b1;
                w_pick   = IDXW'(w_j);
                w_pstart = req_start[w_j*WIDTH +: WIDTH];
                w_plen   = req_len[w_j*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_state  = r_state;
        w_last   = r_last;
        w_idx    = r_idx;
        w_rem    = r_rem;
        w_gnt    = gnt;
        w_busy   = busy;
        w_done   = '0;
        w_ld     = 1'b0;
        w_ld_val = cnt_ld_val;
        w_inc    = 1'b0;
        w_result = result;
        w_end    = (r_rem == WIDTH'(1)) || w_abort;
        case (r_state)
            IDLE: if (w_found) begin
                w_state        = LOAD;
                w_idx          = w_pick;
                w_gnt          = '0;
                w_gnt[w_pick]  = 1'b1;
                w_busy         = 1'b1;
                w_ld           = 1'b1;
                w_ld_val       = w_pstart;
                w_rem          = w_plen;
            end
            LOAD: begin
                w_state = (r_rem == '0) ? DONE : RUN;
                w_inc   = (r_rem != '0);
            end
            RUN: begin
                w_rem   = r_rem - 1'b1;
                w_state = w_end ? DONE : RUN;
                w_inc   = !w_end;
            end
            DONE: begin
                w_state  = IDLE;
                w_result = cnt_value;
                w_done   = gnt;
                w_gnt    = '0;
                w_busy   = 1'b0;
                w_last   = r_idx;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_last     <= IDXW'(NUM_REQ - 1);
            r_idx      <= '0;
            r_rem      <= '0;
            gnt        <= '0;
            busy       <= 1'b0;
            done       <= '0;
            cnt_ld     <= 1'b0;
            cnt_ld_val <= '0;
            cnt_inc    <= 1'b0;
            result     <= '0;
        end else begin
            r_state    <= w_state;
            r_last     <= w_last;
            r_idx      <= w_idx;
            r_rem      <= w_rem;
            gnt        <= w_gnt;
            busy       <= w_busy;
            done       <= w_done;
            cnt_ld     <= w_ld;
            cnt_ld_val <= w_ld_val;
            cnt_inc    <= w_inc;
            result     <= w_result;
        end
    end

`ifdef CNT_SCHED_ABORT_EN
    logic r_abt;

    // Remember an abort seen in RUN and publish it alongside the done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_abt   <= 1'b0;
            aborted <= 1'b0;
        end else begin
            r_abt   <= (r_state == RUN && abort) ? 1'b1 : (r_state == DONE) ? 1'b0 : r_abt;
            aborted <= (r_state == DONE) ? r_abt : aborted;
        end
    end
`endif

endmodule
